// File: rtl/ssram_bwe.sv
// Simple dual-port synchronous RAM with per-byte write enables, selectable
// read-during-write behaviour, optional output register and a zeroing clear engine.
module ssram_bwe #(
    parameter int Depth       = 512,
    parameter int Width       = 32,
    parameter int ByteW       = 8,
    parameter int RdwMode     = 0,
    parameter int OutReg      = 0,
    parameter int InitOnReset = 1,
    localparam int AddrLines  = $clog2(Depth),
    localparam int Lanes      = Width / ByteW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 WrEn,
    input  logic [AddrLines-1:0] WrAddr,
    input  logic [Width-1:0]     WrData,
    input  logic [Lanes-1:0]     WrBe,
    input  logic                 RdEn,
    input  logic [AddrLines-1:0] RdAddr,
    input  logic                 ClrReq,
    output logic [Width-1:0]     RdData,
    output logic                 RdValid,
    output logic                 InitBusy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam state_t ResetState = (InitOnReset != 0) ? CLEAR : IDLE;
    localparam logic [AddrLines-1:0] LastAddr = AddrLines'(Depth - 1);

    state_t               state_q, state_d;
    logic [AddrLines-1:0] cnt_q, cnt_d;
    logic [Width-1:0]     rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    logic                 busy;
    logic                 wr_in_range, rd_in_range;
    logic                 wr_fire, rd_fire;
    logic                 mem_we;
    logic [AddrLines-1:0] mem_waddr;
    logic [Width-1:0]     mem_wdata;
    logic [Lanes-1:0]     mem_lane_en;
    logic [Width-1:0]     rd_word;

    logic [Width-1:0]     mem_q [Depth];

    // Range checks only exist when the address space is larger than the array.
    if (Depth == (1 << AddrLines)) begin : g_pow2
        assign wr_in_range = 1'b1;
        assign rd_in_range = 1'b1;
    end else begin : g_npow2
        localparam int AW1 = AddrLines + 1;
        localparam logic [AddrLines:0] DepthW = AW1'(Depth);
        assign wr_in_range = ({1'b0, WrAddr} < DepthW);
        assign rd_in_range = ({1'b0, RdAddr} < DepthW);
    end

    assign busy    = (state_q == CLEAR);
    assign wr_fire = WrEn && !busy && wr_in_range;
    assign rd_fire = RdEn && !busy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ClrReq) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == LastAddr) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AddrLines'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The clear engine owns the single write port while busy; no writes during reset.
    always_comb begin
        mem_we      = 1'b0;
        mem_waddr   = WrAddr;
        mem_wdata   = WrData;
        mem_lane_en = WrBe;
        if (busy) begin
            mem_we      = 1'b1;
            mem_waddr   = cnt_q;
            mem_wdata   = '0;
            mem_lane_en = '1;
        end else if (wr_fire) begin
            mem_we = 1'b1;
        end
        if (!rst_n) begin
            mem_we = 1'b0;
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem_q[RdAddr];
            if ((RdwMode != 0) && wr_fire && (WrAddr == RdAddr)) begin
                for (int i = 0; i < Lanes; i++) begin
                    if (WrBe[i]) begin
                        rd_word[i*ByteW +: ByteW] = WrData[i*ByteW +: ByteW];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < Lanes; i++) begin
                if (mem_lane_en[i]) begin
                    mem_q[mem_waddr][i*ByteW +: ByteW] <= mem_wdata[i*ByteW +: ByteW];
                end
            end
        end
    end

    if (OutReg != 0) begin : g_outreg
        logic             p1_valid_q, p1_valid_d;
        logic [Width-1:0] p1_data_q, p1_data_d;

        always_comb begin
            p1_valid_d = rd_fire;
            p1_data_d  = rd_fire ? rd_word : p1_data_q;
            rd_valid_d = p1_valid_q;
            rd_data_d  = p1_valid_q ? p1_data_q : rd_data_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                p1_valid_q <= 1'b0;
                p1_data_q  <= '0;
            end else begin
                p1_valid_q <= p1_valid_d;
                p1_data_q  <= p1_data_d;
            end
        end
    end else begin : g_direct
        always_comb begin
            rd_valid_d = rd_fire;
            rd_data_d  = rd_fire ? rd_word : rd_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ResetState;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign RdData   = rd_data_q;
    assign RdValid  = rd_valid_q;
    assign InitBusy = busy;

endmodule

// File: tb/tb_ssram_bwe.sv
// Directed bench for ssram_bwe: three configurations share one stimulus stream and are
// checked every cycle against a word-level model plus hand-computed literal expectations.
module tb_ssram_bwe;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        rd_en = 1'b0;
    logic [3:0]  rd_addr = '0;
    logic        clr_req = 1'b0;

    logic [31:0] rd_data  [NI];
    logic        rd_valid [NI];
    logic        init_busy[NI];

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    // a: old-data RDW, no output register; b: new-data RDW with output register; c: non-power-of-two depth
    ssram_bwe #(.Depth(16), .Width(32), .ByteW(8), .RdwMode(0), .OutReg(0), .InitOnReset(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
        .RdEn(rd_en), .RdAddr(rd_addr), .ClrReq(clr_req),
        .RdData(rd_data[0]), .RdValid(rd_valid[0]), .InitBusy(init_busy[0]));

    ssram_bwe #(.Depth(16), .Width(32), .ByteW(8), .RdwMode(1), .OutReg(1), .InitOnReset(1)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
        .RdEn(rd_en), .RdAddr(rd_addr), .ClrReq(clr_req),
        .RdData(rd_data[1]), .RdValid(rd_valid[1]), .InitBusy(init_busy[1]));

    ssram_bwe #(.Depth(12), .Width(32), .ByteW(8), .RdwMode(0), .OutReg(0), .InitOnReset(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .WrBe(wr_be),
        .RdEn(rd_en), .RdAddr(rd_addr), .ClrReq(clr_req),
        .RdData(rd_data[2]), .RdValid(rd_valid[2]), .InitBusy(init_busy[2]));

    function automatic int depOf(int n);
        return (n == 2) ? 12 : 16;
    endfunction

    function automatic bit newDataOf(int n);
        return (n == 1);
    endfunction

    function automatic bit outRegOf(int n);
        return (n == 1);
    endfunction

    function automatic logic [31:0] laneMerge(logic [31:0] old_w, logic [31:0] new_w, logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Word-level model: busy_left counts remaining clear edges; a clear zeroes the whole array at once
    logic [31:0] mdl_mem  [NI][16];
    int          busy_left[NI];
    logic [31:0] exp_data [NI];
    logic        exp_valid[NI];
    logic        pipe_v   [NI];
    logic [31:0] pipe_d   [NI];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NI; n++) begin
                busy_left[n] = depOf(n);
                exp_data[n]  = '0;
                exp_valid[n] = 1'b0;
                pipe_v[n]    = 1'b0;
                pipe_d[n]    = '0;
                for (int a = 0; a < 16; a++) mdl_mem[n][a] = '0;
            end
        end else begin
            for (int n = 0; n < NI; n++) begin
                bit          busy_now, rd_ok, wr_ok;
                logic [31:0] res;
                busy_now = (busy_left[n] > 0);
                rd_ok    = rd_en && !busy_now;
                wr_ok    = wr_en && !busy_now && (int'(wr_addr) < depOf(n));
                res      = '0;
                if (rd_ok && (int'(rd_addr) < depOf(n))) begin
                    res = mdl_mem[n][rd_addr];
                    if (newDataOf(n) && wr_ok && (wr_addr == rd_addr)) res = laneMerge(res, wr_data, wr_be);
                end
                if (outRegOf(n)) begin
                    exp_valid[n] = pipe_v[n];
                    if (pipe_v[n]) exp_data[n] = pipe_d[n];
                    pipe_v[n] = rd_ok;
                    pipe_d[n] = res;
                end else begin
                    exp_valid[n] = rd_ok;
                    if (rd_ok) exp_data[n] = res;
                end
                if (busy_now) begin
                    busy_left[n]--;
                end else begin
                    if (wr_ok) mdl_mem[n][wr_addr] = laneMerge(mdl_mem[n][wr_addr], wr_data, wr_be);
                    if (clr_req) begin
                        busy_left[n] = depOf(n);
                        for (int a = 0; a < 16; a++) mdl_mem[n][a] = '0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int n = 0; n < NI; n++) begin
                checkOutput($sformatf("model_valid%0d", n), 32'(rd_valid[n]), 32'(exp_valid[n]));
                checkOutput($sformatf("model_busy%0d", n), 32'(init_busy[n]), 32'(busy_left[n] > 0));
                checkOutput($sformatf("model_data%0d", n), rd_data[n], exp_data[n]);
            end
        end
    end

    // Drives one edge's worth of inputs, then returns 1 time unit after that edge
    task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                                 input logic [3:0] be, input logic re, input logic [3:0] ra,
                                 input logic clr);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        rd_en   = re;
        rd_addr = ra;
        clr_req = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic readAddr(input logic [3:0] ra);
        applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, ra, 1'b0);
    endtask

    task automatic writeWord(input logic [3:0] wa, input logic [31:0] wd, input logic [3:0] be);
        applyStimulus(1'b1, wa, wd, be, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic countBusy(output int n);
        n = 0;
        while (init_busy[0] && n < 100) begin
            idle();
            n++;
        end
    endtask

    initial begin
        int n;
        #2;
        rst_n  = 1'b0;
        cmp_en = 1'b1;
        #2;
        checkOutput("reset_data", rd_data[0], 32'h0);
        checkOutput("reset_valid", 32'(rd_valid[1]), 32'h0);
        checkOutput("reset_busy", 32'(init_busy[0]), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countBusy(n);
        checkOutput("init_busy_edges", 32'(n), 32'd16);

        for (int i = 0; i < 16; i++) begin
            readAddr(4'(i));
            if (i == 0) begin
                checkOutput("init_read0_data", rd_data[0], 32'h0);
                checkOutput("init_read0_valid", 32'(rd_valid[0]), 32'h1);
            end
        end
        idle();
        idle();

        writeWord(4'd3, 32'hAABBCCDD, 4'b1111);
        writeWord(4'd3, 32'h11223344, 4'b0101);
        readAddr(4'd3);
        checkOutput("lane_merge_a", rd_data[0], 32'hAA22CC44);
        idle();
        checkOutput("lane_merge_b", rd_data[1], 32'hAA22CC44);

        applyStimulus(1'b1, 4'd3, 32'h55667788, 4'b0011, 1'b1, 4'd3, 1'b0);
        checkOutput("rdw_old_a", rd_data[0], 32'hAA22CC44);
        checkOutput("rdw_old_c", rd_data[2], 32'hAA22CC44);
        idle();
        checkOutput("rdw_new_b", rd_data[1], 32'hAA227788);
        readAddr(4'd3);
        checkOutput("rdw_after_a", rd_data[0], 32'hAA227788);

        writeWord(4'd3, 32'hFFFFFFFF, 4'b0000);
        readAddr(4'd3);
        checkOutput("be_zero_noop", rd_data[0], 32'hAA227788);

        writeWord(4'd4, 32'hCAFEF00D, 4'b1111);
        readAddr(4'd4);
        checkOutput("wr_then_rd", rd_data[0], 32'hCAFEF00D);

        writeWord(4'd13, 32'hDEADBEEF, 4'b1111);
        readAddr(4'd13);
        checkOutput("oob_read_c_data", rd_data[2], 32'h0);
        checkOutput("oob_read_c_valid", 32'(rd_valid[2]), 32'h1);
        checkOutput("inrange_13_a", rd_data[0], 32'hDEADBEEF);

        for (int i = 0; i < 3; i++) writeWord(4'(i), 32'h00000100 + 32'(i), 4'b1111);
        readAddr(4'd0);
        checkOutput("outreg_lat_v0", 32'(rd_valid[1]), 32'h0);
        readAddr(4'd1);
        checkOutput("outreg_v1", 32'(rd_valid[1]), 32'h1);
        checkOutput("outreg_d1", rd_data[1], 32'h00000100);
        readAddr(4'd2);
        checkOutput("outreg_d2", rd_data[1], 32'h00000101);
        idle();
        checkOutput("outreg_d3", rd_data[1], 32'h00000102);
        idle();
        checkOutput("outreg_v_end", 32'(rd_valid[1]), 32'h0);
        checkOutput("outreg_hold", rd_data[1], 32'h00000102);

        for (int i = 0; i < 16; i++) writeWord(4'(i), 32'hFFFFFFFF, 4'b1111);
        applyStimulus(1'b1, 4'd5, 32'h00001234, 4'b1111, 1'b1, 4'd5, 1'b1);
        checkOutput("clr_edge_read_a", rd_data[0], 32'hFFFFFFFF);
        checkOutput("clr_busy_rise", 32'(init_busy[0]), 32'h1);
        for (int j = 1; j <= 16; j++) begin
            applyStimulus(1'b1, 4'(j - 1), 32'h5A5A5A5A, 4'b1111, 1'b1, 4'(j - 1), (j == 5));
            if (j == 1) checkOutput("clr_pipe_b", rd_data[1], 32'h00001234);
            if (j == 3) checkOutput("clr_drop_valid", 32'(rd_valid[0]), 32'h0);
            if (j == 15) checkOutput("clr_busy_k15", 32'(init_busy[0]), 32'h1);
            if (j == 16) checkOutput("clr_busy_k16", 32'(init_busy[0]), 32'h0);
        end
        for (int i = 0; i < 16; i++) begin
            readAddr(4'(i));
            if (i == 5) checkOutput("clr_zero_5", rd_data[0], 32'h0);
        end
        idle();

        applyStimulus(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, 1'b1);
        for (int j = 0; j < 7; j++) idle();
        rst_n = 1'b0;
        #1;
        checkOutput("midclr_rst_valid", 32'(rd_valid[1]), 32'h0);
        checkOutput("midclr_rst_data", rd_data[1], 32'h0);
        checkOutput("midclr_rst_busy", 32'(init_busy[0]), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countBusy(n);
        checkOutput("midclr_busy_edges", 32'(n), 32'd16);

        readAddr(4'd4);
        rst_n = 1'b0;
        #1;
        checkOutput("flush_valid_a", 32'(rd_valid[0]), 32'h0);
        checkOutput("flush_valid_b", 32'(rd_valid[1]), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        countBusy(n);
        checkOutput("flush_busy_edges", 32'(n), 32'd16);
        idle();
        idle();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssram_bwe.md
# ssram_bwe

Parametrised simple dual-port synchronous RAM: the next generation of the team's single-clock SRAM primitive and the storage element for the synchronous FIFOs. It adds per-byte write enables, a selectable read-during-write policy, an optional output register stage with a read-valid strobe, and a hardware clear engine. The clear engine zeroes the array after reset or on request. One write port and one read port share a single clock.

## Interface
- Depth, 512: number of words. Any value ≥ 2; need not be a power of two. AddrLines = $clog2(Depth).
- Width, 32: word width in bits. Must be an integer multiple of ByteW.
- ByteW, 8: lane width. Lanes = Width/ByteW.
- RdwMode, 0: same-address read/write in one cycle. 0 = return old data; 1 = return new (merged) data.
- OutReg, 0: 0 = read latency 1; 1 = extra output register, read latency 2.
- InitOnReset, 1: 1 = clear engine runs automatically after reset release.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- WrEn  in  1  write request.
- WrAddr  in  AddrLines  write address.
- WrData  in  Width  write data. Lane i is bits [i*ByteW +: ByteW].
- WrBe  in  Lanes  per-lane write enable.
- RdEn  in  1  read request.
- RdAddr  in  AddrLines  read address.
- ClrReq  in  1  single-cycle request to zero the whole array.
- RdData  out  Width  read data, registered.
- RdValid  out  1  one-cycle strobe: RdData carries a new read result.
- InitBusy  out  1  clear engine active. While high, all WrEn and RdEn requests are dropped.

## Operation
- **Reset values:**
  - RdData = 0, RdValid = 0, all pipeline valids = 0.
  - Clear counter = 0.
  - InitBusy = 1 if InitOnReset, else 0.
  - The array itself is not reset.
- **Write:** at the edge where WrEn=1 and InitBusy=0, each lane with WrBe[i]=1 is updated; other lanes keep their value.
  - WrBe = 0 is a no-op.
  - WrAddr ≥ Depth is ignored.
- **Read:** at the edge where RdEn=1 and InitBusy=0, the word is captured.
  - RdAddr ≥ Depth returns all-zero data with RdValid asserted.
  - RdData holds its last value when no read completes; it is never cleared except by reset.
- **Read-during-write to the same address, same edge:**
  - RdwMode=0: the full old word is returned.
  - RdwMode=1: lanes with WrBe set return WrData; the remaining lanes return old data.
  - Different addresses never interact.
- **Clear FSM, states IDLE and CLEAR:**
  - IDLE→CLEAR on release of rst_n when InitOnReset=1, or on ClrReq=1 sampled in IDLE.
  - CLEAR writes zero to address cnt on each edge, cnt = 0..Depth-1. Returns to IDLE on the edge that writes Depth-1; cnt returns to 0.
  - ClrReq during CLEAR is ignored; it is not queued.
- **Simultaneous events:**
  - WrEn/RdEn at the same edge as an accepted ClrReq (FSM still IDLE) are accepted; the write is then overwritten by the clear.
  - Reads already in the OutReg pipeline complete normally during CLEAR.
- **Reset mid-operation:** asserting rst_n aborts the clear immediately and flushes in-flight reads (RdValid = 0).
  - After release, the clear restarts from address 0 if InitOnReset=1.
  - If InitOnReset=0, array contents are unspecified.

## Timing
- Read latency, edge of acceptance = edge k:
  - OutReg=0: RdData/RdValid update after edge k.
  - OutReg=1: RdData/RdValid update after edge k+1.
- Throughput is one read and one write per cycle. There is no backpressure.
- RdValid is high for exactly one cycle per accepted read. Back-to-back reads give a continuous RdValid.
- A write at edge k is visible to a different-port read accepted at edge k+1 in either mode.
- Auto-clear: InitBusy is high during reset.
  - First zero-write is to address 0 at the first rising edge with rst_n=1.
  - InitBusy falls after edge Depth, i.e. Depth busy cycles.
- ClrReq sampled at edge k: InitBusy rises after edge k, zeroes addresses at edges k+1..k+Depth, and falls after edge k+Depth.

## Test plan
- Depth=16, Width=32, InitOnReset=1: release reset, count cycles → InitBusy high for exactly 16 edges. Then reads of addresses 0..15 all return 0x00000000 with RdValid.
- Write 0xAABBCCDD with WrBe=4'b1111 to addr 3, then 0x11223344 with WrBe=4'b0101 to addr 3; read addr 3 → 0xAA22CC44.
- Same-edge write of 0x55667788 (WrBe=4'b0011) and read of addr 3 holding 0xAA22CC44:
  - RdwMode=0 → 0xAA22CC44.
  - RdwMode=1 → 0xAA227788.
- OutReg=1: reads of addr 0,1,2 on consecutive edges → RdValid high for 3 cycles starting 2 cycles after the first request, with data in address order.
- Pulse ClrReq at edge k after filling the array with 0xFFFFFFFF:
  - WrEn/RdEn at edges k+1..k+16 are dropped, with no RdValid.
  - InitBusy falls after edge k+16, and all words then read 0.
  - A second ClrReq at k+5 does not extend the busy window.
- Assert rst_n low mid-clear at cnt=7 with an OutReg read in flight → RdValid and RdData go to 0 immediately. After release, InitBusy lasts a full 16 edges.
